// File: rtl/ats21_pkg.sv
// rtl/ats21_pkg.sv - shared ATS21 command front end types and field decode
package ats21_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    OP_NOP      = 3'b000,
    OP_SET_CLK  = 3'b001,
    OP_EN_CLK   = 3'b010,
    OP_SET_MODE = 3'b011,
    OP_RSVD     = 3'b100,
    OP_SET_ALM  = 3'b101,
    OP_SET_TMR  = 3'b110,
    OP_EN_ALM   = 3'b111
  } opcode_e;

  typedef enum logic {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } client_e;

  typedef struct packed {
    client_e     client;
    opcode_e     op;
    logic [4:0]  id;
    logic [3:0]  clk;
    logic        flag;
    logic [1:0]  rate;
    logic [15:0] value;
  } ats21_cmd_t;

  typedef struct packed {
    logic       active;
    logic [1:0] allow_tmr;
    logic [1:0] allow_clk;
  } mode_t;

  localparam mode_t MODE_RESET = '{active: 1'b1, allow_tmr: 2'b11, allow_clk: 2'b11};

  // Splits a {hi,lo} instruction into command fields; fields an opcode does not use stay zero.
  function automatic ats21_cmd_t decode_instr(client_e c, logic [INSTR_W-1:0] instr);
    ats21_cmd_t d;
    logic [15:0] hi;
    hi       = instr[31:16];
    d        = '0;
    d.client = c;
    d.op     = opcode_e'(hi[15:13]);
    d.value  = instr[15:0];
    case (d.op)
      OP_SET_CLK: begin
        d.id   = {1'b0, hi[12:9]};
        d.rate = hi[7:6];
      end
      OP_EN_CLK: begin
        d.id   = {1'b0, hi[12:9]};
        d.flag = hi[7];
      end
      OP_SET_ALM, OP_EN_ALM: begin
        d.id   = hi[12:8];
        d.clk  = hi[3:0];
        d.flag = hi[7];
      end
      OP_SET_TMR: begin
        d.id  = hi[12:8];
        d.clk = hi[3:0];
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ats21_cmd_fifo.sv
// rtl/ats21_cmd_fifo.sv - per-client instruction FIFO, drops pushes when full unless popped
module ats21_cmd_fifo
  import ats21_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = INSTR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a full FIFO still accepts a push when popped on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ats21_cmd_frontend.sv
// rtl/ats21_cmd_frontend.sv - two-beat capture, per-client queues, mode check and round-robin issue
module ats21_cmd_frontend
  import ats21_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] ctrlA,
  input  logic [15:0] ctrlB,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_client,
  output logic [2:0]  cmd_op,
  output logic [4:0]  cmd_id,
  output logic [3:0]  cmd_clk,
  output logic        cmd_flag,
  output logic [1:0]  cmd_rate,
  output logic [15:0] cmd_value,
  output logic        mode_active,
  output logic [1:0]  ovf,
  output logic [1:0]  reject,
  output logic        proto_err
);

  typedef enum logic [1:0] {CAP_IDLE, CAP_HI, CAP_LO} cap_state_e;

  cap_state_e   cap_state, cap_next;
  logic         cap_latch_hi, cap_push, proto_hit;
  logic [15:0]  hi_a, hi_b;
  logic         push_a, push_b, full_a, full_b, empty_a, empty_b;
  logic [31:0]  data_a, data_b, pop_instr;
  logic         slot_free, gnt_a, gnt_b, any_pop;
  client_e      rr, pop_client;
  ats21_cmd_t   dec, slot;
  mode_t        mode;
  logic         fwd, rej, mode_upd;

  // Capture state register.
  always_ff @(posedge clk) begin
    if (reset) cap_state <= CAP_IDLE;
    else       cap_state <= cap_next;
  end

  // Capture sequencing: req starts a hi/lo pair; req during the pair is flagged and otherwise ignored.
  always_comb begin
    cap_next     = cap_state;
    cap_latch_hi = 1'b0;
    cap_push     = 1'b0;
    proto_hit    = 1'b0;
    case (cap_state)
      CAP_IDLE: if (req) cap_next = CAP_HI;
      CAP_HI: begin
        cap_latch_hi = 1'b1;
        proto_hit    = req;
        cap_next     = CAP_LO;
      end
      CAP_LO: begin
        cap_push  = 1'b1;
        proto_hit = req;
        cap_next  = CAP_IDLE;
      end
      default: cap_next = CAP_IDLE;
    endcase
  end

  // Hold the hi halves until the lo halves arrive on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_a <= '0;
      hi_b <= '0;
    end else if (cap_latch_hi) begin
      hi_a <= ctrlA;
      hi_b <= ctrlB;
    end
  end

  // A NOP opcode means the client had nothing to say this time.
  assign push_a = cap_push && (opcode_e'(hi_a[15:13]) != OP_NOP);
  assign push_b = cap_push && (opcode_e'(hi_b[15:13]) != OP_NOP);

  ats21_cmd_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .reset(reset), .push(push_a), .push_data({hi_a, ctrlA}),
    .pop(gnt_a), .pop_data(data_a), .full(full_a), .empty(empty_a)
  );

  ats21_cmd_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .reset(reset), .push(push_b), .push_data({hi_b, ctrlB}),
    .pop(gnt_b), .pop_data(data_b), .full(full_b), .empty(empty_b)
  );

  assign slot_free  = !cmd_valid || cmd_ready;
  assign gnt_a      = slot_free && !empty_a && (empty_b || rr == CLIENT_A);
  assign gnt_b      = slot_free && !empty_b && (empty_a || rr == CLIENT_B);
  assign any_pop    = gnt_a || gnt_b;
  assign pop_client = gnt_b ? CLIENT_B : CLIENT_A;
  assign pop_instr  = gnt_b ? data_b : data_a;
  assign dec        = decode_instr(pop_client, pop_instr);

  // Permission check on the popped instruction against the mode in force before this pop.
  always_comb begin
    fwd      = 1'b0;
    rej      = 1'b0;
    mode_upd = 1'b0;
    if (any_pop) begin
      case (dec.op)
        OP_SET_MODE:                     mode_upd = 1'b1;
        OP_SET_CLK, OP_EN_CLK:           if (mode.active && mode.allow_clk[pop_client]) fwd = 1'b1; else rej = 1'b1;
        OP_SET_ALM, OP_SET_TMR, OP_EN_ALM: if (mode.active && mode.allow_tmr[pop_client]) fwd = 1'b1; else rej = 1'b1;
        default:                         rej = 1'b1;
      endcase
    end
  end

  // Issue-side state: output slot, mode register, arbitration pointer and event pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      slot      <= '0;
      mode      <= MODE_RESET;
      rr        <= CLIENT_A;
      ovf       <= '0;
      reject    <= '0;
      proto_err <= 1'b0;
    end else begin
      ovf       <= {push_b && full_b && !gnt_b, push_a && full_a && !gnt_a};
      reject    <= {rej && (pop_client == CLIENT_B), rej && (pop_client == CLIENT_A)};
      proto_err <= proto_hit;
      if (mode_upd)
        mode <= '{active: pop_instr[28], allow_tmr: pop_instr[27:26], allow_clk: pop_instr[25:24]};
      if (slot_free && !empty_a && !empty_b)
        rr <= (rr == CLIENT_A) ? CLIENT_B : CLIENT_A;
      if (fwd) begin
        slot      <= dec;
        cmd_valid <= 1'b1;
      end else if (cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

  assign cmd_client  = slot.client;
  assign cmd_op      = slot.op;
  assign cmd_id      = slot.id;
  assign cmd_clk     = slot.clk;
  assign cmd_flag    = slot.flag;
  assign cmd_rate    = slot.rate;
  assign cmd_value   = slot.value;
  assign mode_active = mode.active;

endmodule

// File: tb/tb_ats21_cmd_frontend.sv
// tb/tb_ats21_cmd_frontend.sv - scoreboard bench with a queue-based reference model
module tb_ats21_cmd_frontend;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, req, cmd_ready;
  logic [15:0] ctrlA, ctrlB;
  logic        cmd_valid, cmd_client, cmd_flag, mode_active, proto_err;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_id;
  logic [3:0]  cmd_clk;
  logic [1:0]  cmd_rate, ovf, reject;
  logic [15:0] cmd_value;

  always #5 clk = ~clk;

  ats21_cmd_frontend #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_client(cmd_client),
    .cmd_op(cmd_op), .cmd_id(cmd_id), .cmd_clk(cmd_clk), .cmd_flag(cmd_flag),
    .cmd_rate(cmd_rate), .cmd_value(cmd_value), .mode_active(mode_active),
    .ovf(ovf), .reject(reject), .proto_err(proto_err)
  );

  typedef struct packed {
    logic        client;
    logic [2:0]  op;
    logic [4:0]  id;
    logic [3:0]  clk;
    logic        flag;
    logic [1:0]  rate;
    logic [15:0] value;
  } exp_cmd_t;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  bit rand_rdy = 0;

  exp_cmd_t    expq[$];
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  bit          m_valid, m_rr, m_active;
  logic [1:0]  m_tmr, m_clk, e_ovf, e_rej;
  bit          e_proto;
  int          m_stage;
  logic [15:0] m_hia, m_hib;

  // Expected fields straight from the instruction field rules.
  function automatic exp_cmd_t ref_cmd(bit c, logic [31:0] ins);
    exp_cmd_t r;
    int op;
    op = ins[31:29];
    r = '0;
    r.client = c;
    r.op = ins[31:29];
    r.value = ins[15:0];
    if (op == 1 || op == 2) r.id = (ins[31:16] >> 9) & 16'hF;
    else                    r.id = ins[28:24];
    if (op >= 5) r.clk = ins[19:16];
    if (op == 2 || op == 5 || op == 7) r.flag = ins[23];
    if (op == 1) r.rate = ins[23:22];
    return r;
  endfunction

  // Reference model: advances once per clock edge using the inputs present at that edge.
  always @(posedge clk) begin
    bit free, c, ok;
    logic [31:0] ins;
    int op;
    if (reset) begin
      qa.delete(); qb.delete(); expq.delete();
      m_valid = 0; m_rr = 0; m_active = 1; m_tmr = 2'b11; m_clk = 2'b11;
      m_stage = 0; e_ovf = 0; e_rej = 0; e_proto = 0; m_hia = 0; m_hib = 0;
    end else begin
      e_ovf = 0; e_rej = 0; e_proto = 0;
      free = !m_valid || cmd_ready;
      if (m_valid && cmd_ready) m_valid = 0;
      if (free && (qa.size() > 0 || qb.size() > 0)) begin
        if (qa.size() > 0 && qb.size() > 0) begin
          c = m_rr;
          m_rr = !m_rr;
        end else begin
          c = (qb.size() > 0);
        end
        ins = c ? qb.pop_front() : qa.pop_front();
        op = ins[31:29];
        if (op == 3) begin
          m_active = ins[28]; m_tmr = ins[27:26]; m_clk = ins[25:24];
        end else begin
          if (op == 1 || op == 2)  ok = m_active && m_clk[c];
          else if (op >= 5)        ok = m_active && m_tmr[c];
          else                     ok = 0;
          if (ok) begin
            m_valid = 1;
            expq.push_back(ref_cmd(c, ins));
          end else begin
            e_rej[c] = 1;
          end
        end
      end
      case (m_stage)
        0: if (req) m_stage = 1;
        1: begin
          m_hia = ctrlA; m_hib = ctrlB;
          if (req) e_proto = 1;
          m_stage = 2;
        end
        default: begin
          if (req) e_proto = 1;
          m_stage = 0;
          if (m_hia[15:13] != 0) begin
            if (qa.size() >= DEPTH) e_ovf[0] = 1; else qa.push_back({m_hia, ctrlA});
          end
          if (m_hib[15:13] != 0) begin
            if (qb.size() >= DEPTH) e_ovf[1] = 1; else qb.push_back({m_hib, ctrlB});
          end
        end
      endcase
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    exp_cmd_t e, g;
    if (mon_en) begin
      checks++;
      if ({cmd_valid, ovf, reject, proto_err, mode_active} !== {m_valid, e_ovf, e_rej, e_proto, m_active}) begin
        errors++;
        $display("FAIL status t=%0t got v=%b ovf=%b rej=%b perr=%b act=%b want v=%b ovf=%b rej=%b perr=%b act=%b",
                 $time, cmd_valid, ovf, reject, proto_err, mode_active, m_valid, e_ovf, e_rej, e_proto, m_active);
      end
      if (cmd_valid && cmd_ready && !reset) begin
        checks++;
        g = '{client: cmd_client, op: cmd_op, id: cmd_id, clk: cmd_clk, flag: cmd_flag, rate: cmd_rate, value: cmd_value};
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected t=%0t got=%h want=none", $time, g);
        end else begin
          e = expq.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL cmd t=%0t got c=%b op=%b id=%0d clk=%0d f=%b r=%0d v=%h want c=%b op=%b id=%0d clk=%0d f=%b r=%0d v=%h",
                     $time, g.client, g.op, g.id, g.clk, g.flag, g.rate, g.value,
                     e.client, e.op, e.id, e.clk, e.flag, e.rate, e.value);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) cmd_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic instr(input logic [15:0] ahi, input logic [15:0] alo,
                       input logic [15:0] bhi, input logic [15:0] blo,
                       input bit req_hi, input bit req_lo);
    req = 1; ctrlA = 16'($urandom); ctrlB = 16'($urandom);
    tick();
    req = req_hi; ctrlA = ahi; ctrlB = bhi;
    tick();
    req = req_lo; ctrlA = alo; ctrlB = blo;
    tick();
    req = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [15:0] gen_hi();
    logic [15:0] h;
    h = 16'($urandom);
    if (h[15:13] == 3'b011) h[12] = ($urandom_range(0, 3) != 0);
    return h;
  endfunction

  initial begin
    reset = 1; req = 0; ctrlA = 0; ctrlB = 0; cmd_ready = 1;
    tick();
    mon_en = 1;
    tick();
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_data", {cmd_op, cmd_id, cmd_clk, cmd_flag, cmd_rate, cmd_value}, 0);
    chk("rst_mode", 32'(mode_active), 1);
    chk("rst_pulses", {ovf, reject, proto_err}, 0);
    reset = 0;
    tick();

    // Both clients issue SET_CLK together: A first, B the cycle after.
    instr(16'h2080, 16'h0000, 16'h2240, 16'h0000, 0, 0);
    tick();
    chk("t1_a", {cmd_valid, cmd_client, cmd_op, cmd_id, cmd_rate}, {1'b1, 1'b0, 3'b001, 5'd0, 2'd2});
    tick();
    chk("t1_b", {cmd_valid, cmd_client, cmd_op, cmd_id, cmd_rate}, {1'b1, 1'b1, 3'b001, 5'd1, 2'd1});
    idle(2);

    // Alarm set from A; B NOP is dropped silently.
    instr(16'hA283, 16'h1234, 16'h0000, 16'h5555, 0, 0);
    tick();
    chk("t2_alm", {cmd_valid, cmd_op, cmd_id, cmd_flag, cmd_clk, cmd_value},
        {1'b1, 3'b101, 5'd2, 1'b1, 4'd3, 16'h1234});
    idle(2);

    // Mode restricts timer ops to nobody and clock ops to A.
    instr(16'h7100, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    instr(16'hC005, 16'h0042, 16'h0000, 16'h0000, 0, 0);
    tick();
    chk("t3_rej_a", {cmd_valid, reject}, {1'b0, 2'b01});
    instr(16'h2080, 16'h0001, 16'h2240, 16'h0002, 0, 0);
    idle(4);

    // Backpressure: six A instructions with the core stalled.
    instr(16'h7F00, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    idle(2);
    cmd_ready = 0;
    for (int i = 0; i < 6; i++) instr(16'h4080 | 16'(i << 9), 16'(i), 16'h0000, 16'h0000, 0, 0);
    cmd_ready = 1;
    idle(8);

    // Extra req during HI and during LO.
    instr(16'hE185, 16'hBEEF, 16'h2600, 16'h0007, 1, 0);
    instr(16'h2080, 16'h0009, 16'h0000, 16'h0000, 0, 1);
    idle(4);

    // Mode goes inactive, reset restores it.
    instr(16'h6000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    idle(2);
    chk("t6_inactive", 32'(mode_active), 0);
    reset = 1;
    tick();
    reset = 0;
    chk("t6_mode_rst", 32'(mode_active), 1);

    // Reset during LO with a loaded slot and queued commands.
    cmd_ready = 0;
    instr(16'h2080, 16'h0001, 16'h2240, 16'h0002, 0, 0);
    instr(16'h6000, 16'h0003, 16'h2240, 16'h0004, 0, 0);
    req = 1; tick();
    req = 0; ctrlA = 16'h2080; ctrlB = 16'h2080; tick();
    reset = 1; tick();
    chk("t6_valid", 32'(cmd_valid), 0);
    chk("t6_mode", 32'(mode_active), 1);
    reset = 0;
    cmd_ready = 1;
    idle(10);
    chk("t6_quiet", 32'(cmd_valid), 0);

    // Randomized traffic with random backpressure.
    rand_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      instr(gen_hi(), 16'($urandom), gen_hi(), 16'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_rdy = 0;
    cmd_ready = 1;
    idle(25);
    chk("drain_empty", 32'(expq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
